// File: rtl/sram_pkg.sv
// Shared types and helpers for the byte-write SRAM and its clear engine.
package sram_pkg;

  localparam int LANE = 8;

  typedef enum logic {
    IDLE,
    CLEAR
  } clr_state_t;

  function automatic int bw_of(input int dw);
    return dw / LANE;
  endfunction

endpackage

// File: rtl/sram_clr_ctrl.sv
// Clear engine: walks every word once, writing zero, while busy is high.
module sram_clr_ctrl
  import sram_pkg::*;
#(
  parameter int AW    = 5,
  parameter int DEPTH = 2**AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  clr_state_t    state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // A clr seen mid-walk rewinds the pointer rather than aborting.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (clr) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        if (clr) begin
          ptr_d = '0;
        end else if (ptr_q == LAST) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: begin
        state_d = CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  assign busy     = (state_q == CLEAR);
  assign clr_we   = busy;
  assign clr_addr = ptr_q;

endmodule

// File: rtl/sram_sp_bwe.sv
// Single-port SRAM with byte enables, registered read and sequenced clear.
module sram_sp_bwe
  import sram_pkg::*;
#(
  parameter int DW    = 16,
  parameter int AW    = 5,
  parameter int DEPTH = 2**AW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ce,
  input  logic            we,
  input  logic [DW/8-1:0] be,
  input  logic [AW-1:0]   addr,
  input  logic [DW-1:0]   din,
  input  logic            clr,
  output logic [DW-1:0]   dout,
  output logic            dout_vld,
  output logic            busy
);

  localparam int          BW  = bw_of(DW);
  localparam logic [AW:0] LIM = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];

  logic          clr_we;
  logic [AW-1:0] clr_addr;
  logic          in_range;
  logic          acc;
  logic          wr;
  logic          rd;

  sram_clr_ctrl #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_clr (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // clr and rst both pre-empt a user access in the same cycle.
  assign in_range = ({1'b0, addr} < LIM);
  assign acc      = ce & ~busy & ~clr & ~rst;
  assign wr       = acc & we & in_range;
  assign rd       = acc & ~we;

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr) begin
      for (int i = 0; i < BW; i++) begin
        if (be[i]) begin
          mem[addr][i*LANE +: LANE] <= din[i*LANE +: LANE];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout     <= '0;
      dout_vld <= 1'b0;
    end else begin
      dout_vld <= rd;
      if (rd) begin
        dout <= in_range ? mem[addr] : '0;
      end
    end
  end

endmodule

// File: tb/tb_sram_sp_bwe.sv
// Randomised and directed checks of sram_sp_bwe against an array model.
module tb_sram_sp_bwe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  be = '0;
  logic [4:0]  addr = '0;
  logic [15:0] din = '0;
  logic        clr = 1'b0;
  logic [15:0] dout, dout2;
  logic        vld, vld2;
  logic        busy, busy2;

  int pass = 0;
  int total = 0;

  logic [15:0] m [32];

  always #5 clk = ~clk;

  sram_sp_bwe #(.DW(16), .AW(5)) dut (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .be(be), .addr(addr),
    .din(din), .clr(clr), .dout(dout), .dout_vld(vld), .busy(busy)
  );

  sram_sp_bwe #(.DW(16), .AW(5), .DEPTH(20)) dut20 (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .be(be), .addr(addr),
    .din(din), .clr(clr), .dout(dout2), .dout_vld(vld2), .busy(busy2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) m[i] = 16'h0;
  endfunction

  function automatic void model_write(input int a, input logic [15:0] d,
                                      input logic [1:0] b);
    if (b[0]) m[a][7:0]  = d[7:0];
    if (b[1]) m[a][15:8] = d[15:8];
  endfunction

  task automatic op(input logic w, input logic [1:0] b,
                    input logic [4:0] a, input logic [15:0] d);
    ce = 1'b1; we = w; be = b; addr = a; din = d;
    tick();
    ce = 1'b0; we = 1'b0; be = '0;
  endtask

  task automatic read_chk(input string nm, input logic [4:0] a,
                          input logic [15:0] exp);
    op(1'b0, 2'b00, a, 16'h0);
    total++;
    if (vld !== 1'b1 || dout !== exp)
      $display("FAIL %s addr=%0d: got vld=%b dout=%h, want vld=1 dout=%h",
               nm, a, vld, dout, exp);
    else pass++;
  endtask

  task automatic busy_len(input string nm, input int exp);
    int n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      tick();
    end
    total++;
    if (n !== exp) $display("FAIL %s busy cycles: got %0d want %0d", nm, n, exp);
    else pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_clear();
    total++;
    if (busy !== 1'b1 || vld !== 1'b0 || dout !== 16'h0)
      $display("FAIL reset_state: got busy=%b vld=%b dout=%h, want 1 0 0000",
               busy, vld, dout);
    else pass++;
    busy_len("reset_clear", 32);
    for (int a = 0; a < 32; a++) read_chk("reset_read", 5'(a), 16'h0);
  endtask

  task automatic test_write_read();
    op(1'b1, 2'b11, 5'd3, 16'hA55A);
    model_write(3, 16'hA55A, 2'b11);
    total++;
    if (vld !== 1'b0) $display("FAIL write_vld: got %b want 0", vld);
    else pass++;
    read_chk("write_read", 5'd3, 16'hA55A);
  endtask

  task automatic test_byte_enable();
    op(1'b1, 2'b01, 5'd3, 16'h1234);
    model_write(3, 16'h1234, 2'b01);
    read_chk("be_low", 5'd3, 16'hA534);
    op(1'b1, 2'b00, 5'd3, 16'hFFFF);
    read_chk("be_none", 5'd3, 16'hA534);
    op(1'b1, 2'b10, 5'd3, 16'h7700);
    model_write(3, 16'h7700, 2'b10);
    read_chk("be_high", 5'd3, m[3]);
  endtask

  task automatic test_clr_collision();
    clr = 1'b1; ce = 1'b1; we = 1'b1; be = 2'b11; addr = 5'd3; din = 16'hFFFF;
    tick();
    clr = 1'b0; ce = 1'b0; we = 1'b0; be = '0;
    model_clear();
    total++;
    if (vld !== 1'b0 || busy !== 1'b1)
      $display("FAIL clr_collide: got vld=%b busy=%b want 0 1", vld, busy);
    else pass++;
    busy_len("clr_len", 32);
    read_chk("clr_zero", 5'd3, 16'h0);
  endtask

  task automatic test_clr_extend();
    int n = 0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    while (busy === 1'b1 && n < 200) begin
      clr = (n == 9);
      n++;
      tick();
      clr = 1'b0;
    end
    total++;
    if (n !== 42) $display("FAIL clr_extend busy cycles: got %0d want 42", n);
    else pass++;
  endtask

  task automatic test_busy_access();
    logic [15:0] held;
    op(1'b1, 2'b11, 5'd7, 16'hC0DE);
    model_write(7, 16'hC0DE, 2'b11);
    read_chk("pre_busy", 5'd7, 16'hC0DE);
    held = dout;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    model_clear();
    op(1'b0, 2'b00, 5'd7, 16'h0);
    total++;
    if (vld !== 1'b0 || dout !== held)
      $display("FAIL busy_read: got vld=%b dout=%h want 0 %h", vld, dout, held);
    else pass++;
    op(1'b1, 2'b11, 5'd9, 16'h5555);
    busy_len("busy_rest", 30);
    read_chk("busy_write_drop", 5'd9, 16'h0);
  endtask

  task automatic test_out_of_range();
    op(1'b1, 2'b11, 5'd25, 16'hBEEF);
    model_write(25, 16'hBEEF, 2'b11);
    read_chk("oor_full", 5'd25, 16'hBEEF);
    total++;
    if (vld2 !== 1'b1 || dout2 !== 16'h0)
      $display("FAIL oor_d20: got vld=%b dout=%h want 1 0000", vld2, dout2);
    else pass++;
  endtask

  task automatic test_random();
    logic [15:0] ed;
    logic        ev;
    logic [15:0] ed2;
    for (int k = 0; k < 300; k++) begin
      ce   = ($urandom_range(0, 3) != 0);
      we   = $urandom_range(0, 1);
      be   = 2'($urandom);
      addr = 5'($urandom);
      din  = 16'($urandom);
      ev   = ce & ~we;
      ed   = ev ? m[addr] : dout;
      ed2  = ev ? ((addr < 20) ? m[addr] : 16'h0) : dout2;
      if (ce && we) model_write(addr, din, be);
      tick();
      total++;
      if (vld !== ev || (ev && dout !== ed))
        $display("FAIL rand%0d: got vld=%b dout=%h want vld=%b dout=%h",
                 k, vld, dout, ev, ed);
      else pass++;
      total++;
      if (vld2 !== ev || (ev && dout2 !== ed2))
        $display("FAIL rand20_%0d: got vld=%b dout=%h want vld=%b dout=%h",
                 k, vld2, dout2, ev, ed2);
      else pass++;
    end
    ce = 1'b0; we = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int a = 0; a < 6; a++) begin
      addr = 5'(a); ce = 1'b1; we = 1'b0;
      tick();
      total++;
      if (vld !== 1'b1 || dout !== m[a])
        $display("FAIL b2b%0d: got vld=%b dout=%h want 1 %h", a, vld, dout, m[a]);
      else pass++;
    end
    ce = 1'b0;
    tick();
    total++;
    if (vld !== 1'b0) $display("FAIL idle_vld: got %b want 0", vld);
    else pass++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_enable();
    test_clr_collision();
    test_clr_extend();
    test_busy_access();
    test_out_of_range();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
